// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } pc_state_t;

    typedef struct packed {
        logic hold;
        logic clear;
    } regr_ctl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous active-low clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         clear_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clear_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/stall controller: load-use stalls, taken-branch flushes and data-memory waits.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned MEM_TIMEOUT    = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             clear_ni,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_hold_o,
    output logic             ifid_hold_o,
    output logic             ifid_clear_o,
    output logic             idex_hold_o,
    output logic             idex_clear_o,
    output logic             exmem_hold_o,
    output logic             exmem_clear_o,
    output logic             memwb_hold_o,
    output logic             memwb_clear_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic             mem_timeout_o
);

    localparam int unsigned LdW   = (LOAD_STALL_CYC > 1) ? $clog2(LOAD_STALL_CYC) : 1;
    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    pc_state_t        state_q, state_d;
    logic [LdW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    regr_ctl_t ifid, idex, exmem, memwb;
    logic      pc_hold;
    logic      ld_haz, mem_wait;

    assign ld_haz = ex_memread_i && (ex_rt_i != REG_ZERO) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    assign mem_wait = mem_req_i && !mem_ready_i;

    always_comb begin
        pc_hold  = 1'b0;
        ifid     = '{hold: 1'b0, clear: 1'b0};
        idex     = '{hold: 1'b0, clear: 1'b0};
        exmem    = '{hold: 1'b0, clear: 1'b0};
        memwb    = '{hold: 1'b0, clear: 1'b0};
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        if (!clear_ni) begin
            ifid.clear  = 1'b1;
            idex.clear  = 1'b1;
            exmem.clear = 1'b1;
            memwb.clear = 1'b1;
        end else if (mem_wait) begin
            // Whole front of the pipe freezes; the MEM result is not yet valid for WB.
            pc_hold     = 1'b1;
            ifid.hold   = 1'b1;
            idex.hold   = 1'b1;
            exmem.hold  = 1'b1;
            memwb.clear = 1'b1;
        end else if (state_q == LDSTALL) begin
            pc_hold    = 1'b1;
            ifid.hold  = 1'b1;
            idex.clear = 1'b1;
            ld_cnt_d   = ld_cnt_q - 1'b1;
            if (ld_cnt_q == LdW'(1)) begin
                state_d = RUN;
            end
        end else if (ex_branch_taken_i) begin
            ifid.clear = 1'b1;
            idex.clear = 1'b1;
        end else if (ld_haz) begin
            pc_hold    = 1'b1;
            ifid.hold  = 1'b1;
            idex.clear = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
                state_d  = LDSTALL;
                ld_cnt_d = LdW'(LOAD_STALL_CYC - 1);
            end
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        if (mem_wait) begin
            wait_cnt_d = wait_cnt_q;
            if (wait_cnt_q != WaitW'(MEM_TIMEOUT)) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (wait_cnt_q >= WaitW'(MEM_TIMEOUT - 1)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clear_ni) begin
            state_q    <= RUN;
            ld_cnt_q   <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i    (clk_i),
        .clear_ni (clear_ni),
        .en_i     (pc_hold),
        .count_o  (stall_count_o)
    );

    assign pc_hold_o     = pc_hold;
    assign ifid_hold_o   = ifid.hold;
    assign ifid_clear_o  = ifid.clear;
    assign idex_hold_o   = idex.hold;
    assign idex_clear_o  = idex.clear;
    assign exmem_hold_o  = exmem.hold;
    assign exmem_clear_o = exmem.clear;
    assign memwb_hold_o  = memwb.hold;
    assign memwb_clear_o = memwb.clear;
    assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench: two controllers (1-cycle and 3-cycle load stall) driven by shared inputs.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, br, mem_req, mem_ready;

    logic [8:0]  oa, ob;
    logic [15:0] cnt_a, cnt_b;
    logic        to_a, to_b;

    int checks   = 0;
    int failures = 0;

    // Output vector order: pc, ifid h/c, idex h/c, exmem h/c, memwb h/c
    localparam logic [8:0] RST  = 9'b0_01_01_01_01;
    localparam logic [8:0] NORM = 9'b0_00_00_00_00;
    localparam logic [8:0] LDS  = 9'b1_10_01_00_00;
    localparam logic [8:0] BR   = 9'b0_01_01_00_00;
    localparam logic [8:0] MW   = 9'b1_10_10_10_01;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .LOAD_STALL_CYC (1),
        .MEM_TIMEOUT    (255),
        .CNT_W          (16)
    ) dut_a (
        .clk_i             (clk),
        .clear_ni          (clear_n),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_uses_rt_i      (id_uses_rt),
        .ex_memread_i      (ex_memread),
        .ex_rt_i           (ex_rt),
        .ex_branch_taken_i (br),
        .mem_req_i         (mem_req),
        .mem_ready_i       (mem_ready),
        .pc_hold_o         (oa[8]),
        .ifid_hold_o       (oa[7]),
        .ifid_clear_o      (oa[6]),
        .idex_hold_o       (oa[5]),
        .idex_clear_o      (oa[4]),
        .exmem_hold_o      (oa[3]),
        .exmem_clear_o     (oa[2]),
        .memwb_hold_o      (oa[1]),
        .memwb_clear_o     (oa[0]),
        .stall_count_o     (cnt_a),
        .mem_timeout_o     (to_a)
    );

    pipe_ctrl #(
        .LOAD_STALL_CYC (3),
        .MEM_TIMEOUT    (3),
        .CNT_W          (16)
    ) dut_b (
        .clk_i             (clk),
        .clear_ni          (clear_n),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_uses_rt_i      (id_uses_rt),
        .ex_memread_i      (ex_memread),
        .ex_rt_i           (ex_rt),
        .ex_branch_taken_i (br),
        .mem_req_i         (mem_req),
        .mem_ready_i       (mem_ready),
        .pc_hold_o         (ob[8]),
        .ifid_hold_o       (ob[7]),
        .ifid_clear_o      (ob[6]),
        .idex_hold_o       (ob[5]),
        .idex_clear_o      (ob[4]),
        .exmem_hold_o      (ob[3]),
        .exmem_clear_o     (ob[2]),
        .memwb_hold_o      (ob[1]),
        .memwb_clear_o     (ob[0]),
        .stall_count_o     (cnt_b),
        .mem_timeout_o     (to_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled well away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic haz(input logic on);
        ex_memread = on;
        ex_rt      = on ? 5'd5 : 5'd0;
        id_rs      = on ? 5'd5 : 5'd0;
        #1;
    endtask

    initial begin
        clear_n = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rt = 1'b0; ex_memread = 1'b0; br = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        chk("rst_out_a", oa, RST);
        chk("rst_out_b", ob, RST);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_b", cnt_b, 0);
        chk("rst_to_b", to_b, 0);
        clear_n = 1'b1; #1;
        chk("idle_a", oa, NORM);

        // Load-use on rs
        haz(1'b1);
        chk("ld1_a", oa, LDS);
        chk("ld1_b", ob, LDS);
        tick(); haz(1'b0);
        chk("ld2_a", oa, NORM);
        chk("ld_cnt_a", cnt_a, 1);
        chk("ld2_b", ob, LDS);
        tick();
        chk("ld3_b", ob, LDS);
        tick();
        chk("ld4_b", ob, NORM);
        chk("ld_cnt_b", cnt_b, 3);

        // No-hazard corner cases
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
        chk("r0_a", oa, NORM);
        ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0; #1;
        chk("rt_unused_a", oa, NORM);
        chk("rt_unused_b", ob, NORM);
        id_uses_rt = 1'b1; #1;
        chk("rt_used_a", oa, LDS);
        tick(); ex_memread = 1'b0; id_uses_rt = 1'b0; id_rt = 5'd0; #1;
        chk("rt_after_a", oa, NORM);
        chk("rt_cnt_a", cnt_a, 2);
        tick(); tick();
        chk("rt_after_b", ob, NORM);
        chk("rt_cnt_b", cnt_b, 6);

        // Branch overrides load-use
        haz(1'b1); br = 1'b1; #1;
        chk("br_a", oa, BR);
        chk("br_b", ob, BR);
        tick(); haz(1'b0); br = 1'b0; #1;
        chk("br_next_b", ob, NORM);
        chk("br_cnt_b", cnt_b, 6);

        // Four wait cycles; timeout of B visible after its third
        mem_req = 1'b1; mem_ready = 1'b0; #1;
        chk("mw1_a", oa, MW);
        chk("mw1_b", ob, MW);
        tick(); tick(); tick();
        chk("mw4_b", ob, MW);
        chk("mw_to_b", to_b, 1);
        chk("mw_to_a", to_a, 0);
        tick(); mem_ready = 1'b1; #1;
        chk("mw_done_a", oa, NORM);
        chk("mw_cnt_a", cnt_a, 6);
        chk("mw_cnt_b", cnt_b, 10);
        tick();
        chk("mw_sticky_b", to_b, 1);

        // Memory wait during LDSTALL freezes the load counter
        mem_req = 1'b0; haz(1'b1);
        tick(); haz(1'b0);
        mem_req = 1'b1; mem_ready = 1'b0; #1;
        chk("lw_mw_b", ob, MW);
        tick(); tick(); mem_ready = 1'b1; #1;
        chk("lw_res1_a", oa, NORM);
        chk("lw_res1_b", ob, LDS);
        tick();
        chk("lw_res2_b", ob, LDS);
        tick();
        chk("lw_end_b", ob, NORM);
        chk("lw_cnt_a", cnt_a, 9);
        chk("lw_cnt_b", cnt_b, 15);

        // Saturate stall_count via a long memory wait
        mem_ready = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        chk("sat_a", cnt_a, 16'hFFFF);
        chk("sat_b", cnt_b, 16'hFFFF);
        chk("sat_to_a", to_a, 1);
        tick();
        chk("sat_hold_a", cnt_a, 16'hFFFF);
        mem_req = 1'b0; mem_ready = 1'b1;

        // Reset in the middle of a multi-cycle load stall
        haz(1'b1);
        tick(); haz(1'b0);
        chk("ab_stall_b", ob, LDS);
        clear_n = 1'b0; #1;
        chk("ab_rst_b", ob, RST);
        tick(); clear_n = 1'b1; #1;
        chk("ab_run_b", ob, NORM);
        chk("ab_cnt_b", cnt_b, 0);
        chk("ab_to_b", to_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
